// File: rtl/apb_ctrl_pkg.sv
// Shared types, default widths and helpers for the round-robin APB master.
package apb_ctrl_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Index following idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer,
// pointer moves to the slot after the winner only when the grant is taken.
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        ptr_d = ptr_q;
        for (int j = 0; j < N; j++) begin
            if (!found && (j >= int'(ptr_q)) && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                ptr_d    = PTR_W'(wrap_inc(j, N));
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                ptr_d    = PTR_W'(wrap_inc(j, N));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin accept, fixed two-cycle
// SETUP/ACCESS sequencing and a one-cycle response pulse to the owner.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata
);

    apb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_write;
    logic [DATA_W-1:0]    sel_wdata;

    // SETUP can never take a new transfer, so the arbiter sees no requests there.
    assign arb_req = (state_q != SETUP) ? req_valid : '0;
    assign accept  = |grant;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .clk    (pclk),
        .rst_n  (presetn),
        .req    (arb_req),
        .advance(accept),
        .grant  (grant)
    );

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // A grant in ACCESS chains straight into the next SETUP without dropping psel.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SETUP;
                    owner_d  = grant;
                    paddr_d  = sel_addr;
                    pwrite_d = sel_write;
                    pwdata_d = sel_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                rsp_valid_d = owner_q;
                rsp_rdata_d = pwrite_q ? '0 : prdata;
                if (accept) begin
                    state_d  = SETUP;
                    owner_d  = grant;
                    paddr_d  = sel_addr;
                    pwrite_d = sel_write;
                    pwdata_d = sel_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = grant;
    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus random traffic checked
// against a transfer-level model of the shared bus.
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;

    always #5 pclk = ~pclk;

    apb_master_arbiter #(
        .NUM_REQ(N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata)
    );

    int total = 0;
    int bad   = 0;

    // Requester-side view: pending requests and their payloads.
    logic [N-1:0]  pend;
    logic [AW-1:0] m_addr  [N];
    logic          m_write [N];
    logic [DW-1:0] m_wdata [N];
    logic [DW-1:0] pr_val;

    // Bus-side view: 0 = bus free, 1 = first bus cycle, 2 = second bus cycle.
    int            ptr_m;
    int            ph_m;
    int            cur_idx;
    logic [AW-1:0] cur_addr;
    logic          cur_write;
    logic [DW-1:0] cur_wdata;
    logic [N-1:0]  exp_rsp;
    logic [DW-1:0] exp_rd;
    int            last_g;
    int            dut_g;

    task automatic model_reset();
        ptr_m     = 0;
        ph_m      = 0;
        cur_idx   = 0;
        cur_addr  = '0;
        cur_write = 1'b0;
        cur_wdata = '0;
        exp_rsp   = '0;
        exp_rd    = '0;
        pend      = '0;
        last_g    = -1;
        dut_g     = -1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        pend[i]    = 1'b1;
        m_addr[i]  = a;
        m_write[i] = w;
        m_wdata[i] = d;
    endtask

    task automatic drive_inputs();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = m_addr[i];
            req_write[i]          = m_write[i];
            req_wdata[i*DW +: DW] = m_wdata[i];
        end
        prdata = pr_val;
    endtask

    // One clock: drive, check everything against the model, advance model and DUT.
    task automatic step();
        int g;
        logic [N-1:0] er;
        logic [N-1:0] oh;
        drive_inputs();
        #1;
        g  = -1;
        er = '0;
        if (ph_m != 1) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        dut_g = -1;
        for (int i = N - 1; i >= 0; i--) if (req_valid[i] && req_ready[i]) dut_g = i;

        total++; if (req_ready !== er) begin bad++; $display("[TB] FAIL ready got=%b want=%b", req_ready, er); end
        total++; if (psel !== (ph_m != 0)) begin bad++; $display("[TB] FAIL psel got=%b want=%b", psel, (ph_m != 0)); end
        total++; if (penable !== (ph_m == 2)) begin bad++; $display("[TB] FAIL penable got=%b want=%b", penable, (ph_m == 2)); end
        total++; if (paddr !== cur_addr) begin bad++; $display("[TB] FAIL paddr got=%h want=%h", paddr, cur_addr); end
        total++; if (pwrite !== cur_write) begin bad++; $display("[TB] FAIL pwrite got=%b want=%b", pwrite, cur_write); end
        total++; if (pwdata !== cur_wdata) begin bad++; $display("[TB] FAIL pwdata got=%h want=%h", pwdata, cur_wdata); end
        total++; if (rsp_valid !== exp_rsp) begin bad++; $display("[TB] FAIL rsp_valid got=%b want=%b", rsp_valid, exp_rsp); end
        if (exp_rsp != '0) begin
            total++; if (rsp_rdata !== exp_rd) begin bad++; $display("[TB] FAIL rsp_rdata got=%h want=%h", rsp_rdata, exp_rd); end
        end

        oh = '0;
        oh[cur_idx] = 1'b1;
        if (ph_m == 2) begin
            exp_rsp = oh;
            exp_rd  = cur_write ? '0 : pr_val;
        end else begin
            exp_rsp = '0;
        end
        if (g >= 0) begin
            cur_idx   = g;
            cur_addr  = m_addr[g];
            cur_write = m_write[g];
            cur_wdata = m_wdata[g];
            ptr_m     = (g + 1) % N;
            ph_m      = 1;
        end else if (ph_m == 1) begin
            ph_m = 2;
        end else begin
            ph_m = 0;
        end
        last_g = g;
        @(posedge pclk);
        #1;
        if (g >= 0) pend[g] = 1'b0;
    endtask

    task automatic drain();
        pend = '0;
        repeat (4) step();
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        model_reset();
        pr_val = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i]  = '0;
            m_write[i] = 1'b0;
            m_wdata[i] = '0;
        end
        drive_inputs();
        repeat (2) @(posedge pclk);
        #3;
        presetn = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (psel !== 1'b0) begin bad++; $display("[TB] FAIL reset_psel got=%b want=0", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("[TB] FAIL reset_penable got=%b want=0", penable); end
        total++; if (pwrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_pwrite got=%b want=0", pwrite); end
        total++; if (paddr !== '0) begin bad++; $display("[TB] FAIL reset_paddr got=%h want=0", paddr); end
        total++; if (pwdata !== '0) begin bad++; $display("[TB] FAIL reset_pwdata got=%h want=0", pwdata); end
        total++; if (rsp_valid !== '0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== '0) begin bad++; $display("[TB] FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    endtask

    task automatic test_single_read();
        pr_val = 32'hDEADBEEF;
        set_req(2, 32'h100, 1'b0, $urandom);
        step();
        total++; if (psel !== 1'b1 || penable !== 1'b0) begin bad++; $display("[TB] FAIL rd_setup got=%b%b want=10", psel, penable); end
        step();
        total++; if (psel !== 1'b1 || penable !== 1'b1) begin bad++; $display("[TB] FAIL rd_access got=%b%b want=11", psel, penable); end
        step();
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("[TB] FAIL rd_rsp_valid got=%b want=0100", rsp_valid); end
        total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_rsp_rdata got=%h want=deadbeef", rsp_rdata); end
        drain();
    endtask

    task automatic test_single_write();
        pr_val = 32'hCAFEF00D;
        set_req(0, 32'h40, 1'b1, 32'h55AA);
        step();
        total++; if (pwrite !== 1'b1 || pwdata !== 32'h55AA) begin bad++; $display("[TB] FAIL wr_setup got=%b/%h want=1/55aa", pwrite, pwdata); end
        step();
        total++; if (pwrite !== 1'b1 || pwdata !== 32'h55AA || penable !== 1'b1) begin bad++; $display("[TB] FAIL wr_access got=%b/%h/%b want=1/55aa/1", pwrite, pwdata, penable); end
        step();
        total++; if (rsp_valid !== 4'b0001 || rsp_rdata !== '0) begin bad++; $display("[TB] FAIL wr_rsp got=%b/%h want=0001/0", rsp_valid, rsp_rdata); end
        drain();
    endtask

    task automatic test_fairness();
        int order [8];
        int acc;
        int guard;
        logic en_exp;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
        acc = 0;
        guard = 0;
        en_exp = 1'b0;
        for (int k = 0; k < 8; k++) order[k] = -1;
        while (acc < 8 && guard < 40) begin
            pr_val = $urandom;
            step();
            guard++;
            if (dut_g >= 0) begin
                order[acc] = dut_g;
                acc++;
            end
            if (acc > 0) begin
                total++;
                if (psel !== 1'b1 || penable !== en_exp) begin bad++; $display("[TB] FAIL fair_bus got=%b%b want=1%b", psel, penable, en_exp); end
                en_exp = ~en_exp;
            end
            if (last_g >= 0 && acc < 8) set_req(last_g, $urandom, 1'($urandom_range(0, 1)), $urandom);
        end
        if (acc < 8) begin
            total++; bad++;
            $display("[TB] FAIL fair_timeout got=%0d want=8", acc);
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (order[k] != k % N) begin bad++; $display("[TB] FAIL fair_order%0d got=%0d want=%0d", k, order[k], k % N); end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        int busy;
        int guard;
        set_req(1, 32'h1000, 1'b1, $urandom);
        n = 1;
        busy = 0;
        guard = 0;
        do begin
            pr_val = $urandom;
            step();
            guard++;
            if (psel === 1'b1) busy++;
            if (last_g == 1 && n < 3) begin
                n++;
                set_req(1, 32'h1000 + 32'(n * 4), 1'($urandom_range(0, 1)), $urandom);
            end
        end while ((ph_m != 0 || pend != '0) && guard < 20);
        total++; if (busy != 6) begin bad++; $display("[TB] FAIL b2b_busy got=%0d want=6", busy); end
        drain();
    endtask

    task automatic test_wrap();
        int seen [3];
        int cnt;
        int guard;
        int want [3];
        want[0] = 3; want[1] = 0; want[2] = 3;
        do_reset();
        for (int k = 0; k < 3; k++) seen[k] = -1;
        set_req(3, 32'h300, 1'b0, $urandom);
        cnt = 0;
        guard = 0;
        step();
        if (dut_g >= 0) begin seen[cnt] = dut_g; cnt++; end
        set_req(0, 32'h000, 1'b0, $urandom);
        set_req(3, 32'h304, 1'b0, $urandom);
        while (cnt < 3 && guard < 20) begin
            pr_val = $urandom;
            step();
            guard++;
            if (dut_g >= 0) begin seen[cnt] = dut_g; cnt++; end
        end
        for (int k = 0; k < 3; k++) begin
            total++; if (seen[k] != want[k]) begin bad++; $display("[TB] FAIL wrap_grant%0d got=%0d want=%0d", k, seen[k], want[k]); end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        set_req(1, 32'h200, 1'b0, $urandom);
        step();
        step();
        presetn = 1'b0;
        #1;
        total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_bus got=%b%b want=00", psel, penable); end
        total++; if (rsp_valid !== '0) begin bad++; $display("[TB] FAIL rst_mid_rsp got=%b want=0", rsp_valid); end
        @(posedge pclk);
        #1;
        total++; if (rsp_valid !== '0) begin bad++; $display("[TB] FAIL rst_mid_rsp_late got=%b want=0", rsp_valid); end
        model_reset();
        drive_inputs();
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        for (int i = 0; i < N; i++) set_req(i, $urandom, 1'b0, $urandom);
        step();
        total++; if (dut_g != 0) begin bad++; $display("[TB] FAIL rst_mid_prio got=%0d want=0", dut_g); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
                else if (pend[i] && $urandom_range(0, 15) == 0)
                    pend[i] = 1'b0;
            end
            pr_val = $urandom;
            step();
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
